// File: rtl/prince_pkg.sv
// Shared definitions for the masked PRINCE round controller: FSM states,
// pass-count constants and the round-constant table.
package prince_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_UPD,
      ST_DONE
   } state_e;

   localparam int unsigned N_PASS    = 11;
   localparam int unsigned MID_ROUND = 6;
   localparam int unsigned RC_MAX    = 11;

   localparam logic [63:0] RC [0:11] = '{
      64'h0000000000000000,
      64'h13198a2e03707344,
      64'ha4093822299f31d0,
      64'h082efa98ec4e6c89,
      64'h452821e638d01377,
      64'hbe5466cf34e90c6c,
      64'h7ef84f78fd955cb1,
      64'h85840851f1ac43aa,
      64'hc882d32f25323c54,
      64'h64a51195e0e3610d,
      64'hd3b5a399ca0c2399,
      64'hc0ac29b7c97c50dd
   };

endpackage

// File: rtl/prince_rc_rom.sv
// Combinational round-constant lookup; indices past the table read as zero.
module prince_rc_rom
   import prince_pkg::*;
(
   input  logic [3:0]  idx_i,
   output logic [63:0] rc_o
);

   always_comb begin
      rc_o = '0;
      for (int i = 0; i <= int'(RC_MAX); i++) begin
         if (idx_i == 4'(i)) rc_o = RC[i];
      end
   end

endmodule

// File: rtl/prince_round_ctrl.sv
// Sequencer for the 2-share PRINCE round datapath: load, 11 passes of
// sbox pipeline + state update, done pulse; stalls on missing randomness.
module prince_round_ctrl #(
   parameter int unsigned SBOX_LAT = 2,
   parameter int unsigned N_PASS   = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        rnd_valid_i,
   output logic        rnd_ack_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        load_o,
   output logic        en_o,
   output logic        upd_o,
   output logic        inv_o,
   output logic        inv2_o,
   output logic [3:0]  round_o,
   output logic [63:0] rc_o,
   output logic [63:0] rc2_o
);
   import prince_pkg::*;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  round_q, round_d;
   logic        in_pass;
   logic [3:0]  rc2_idx;
   logic [63:0] rc_rom, rc2_rom;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         round_q <= round_d;
      end
   end

   // The latency counter only advances on cycles where randomness is consumed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      round_d = round_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            round_d = 4'd1;
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (rnd_valid_i) begin
               if (cnt_q == 3'(SBOX_LAT - 1)) state_d = ST_UPD;
               else cnt_d = cnt_q + 3'd1;
            end
         end
         ST_UPD: begin
            cnt_d = '0;
            if (round_q == 4'(N_PASS)) begin
               round_d = '0;
               state_d = ST_DONE;
            end else begin
               round_d = round_q + 4'd1;
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rc2_idx = round_q + 4'd1;

   prince_rc_rom u_rc_rom (
      .idx_i (round_q),
      .rc_o  (rc_rom)
   );

   prince_rc_rom u_rc2_rom (
      .idx_i (rc2_idx),
      .rc_o  (rc2_rom)
   );

   // All outputs decode registered state; only en/ack see rnd_valid_i directly.
   always_comb begin
      in_pass   = (state_q == ST_RUN) || (state_q == ST_UPD);
      busy_o    = (state_q != ST_IDLE);
      load_o    = (state_q == ST_LOAD);
      done_o    = (state_q == ST_DONE);
      upd_o     = (state_q == ST_UPD);
      en_o      = (state_q == ST_RUN) && rnd_valid_i;
      rnd_ack_o = en_o;
      round_o   = round_q;
      inv_o     = in_pass && (round_q <= 4'(MID_ROUND));
      inv2_o    = in_pass && (round_q != 4'(MID_ROUND));
      rc_o      = in_pass ? rc_rom  : '0;
      rc2_o     = in_pass ? rc2_rom : '0;
   end

endmodule

// File: doc/prince_round_ctrl.md
Name: prince_round_ctrl

Overview:
- Sequencing controller for the masked (GLM, 2-share) PRINCE round datapath.
- Runs one encryption as 11 datapath passes: 5 forward rounds, 1 middle round, 5 inverse rounds.
- Per pass it drives the forward/inverse selects, the middle-layer select, the sbox pipeline enable and the state-register update, and supplies the round constants.
- Stalls cleanly when fresh randomness is unavailable. Sits between the top-level cipher wrapper and the round datapath plus its state registers.

Parameters:
- SBOX_LAT, 2, masked sbox pipeline depth in enabled cycles; allowed range 1..4.
- N_PASS, 11, datapath passes per encryption; fixed by PRINCE, not meant to be overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  request an encryption; sampled only in IDLE.
- rnd_valid_i  in  1  fresh 128-bit randomness present on datapath r input this cycle.
- rnd_ack_o  out  1  randomness consumed this cycle; equals en_o.
- busy_o  out  1  encryption in progress.
- done_o  out  1  one-cycle pulse; state register holds the final round result.
- load_o  out  1  one-cycle pulse; state register captures whitened input shares.
- en_o  out  1  sbox pipeline enable (datapath en).
- upd_o  out  1  state register captures datapath ox/oy.
- inv_o  out  1  datapath inv: 1 = forward round, 0 = inverse round.
- inv2_o  out  1  datapath inv2: 0 only in the middle pass.
- round_o  out  4  current pass number 1..11; 0 outside passes.
- rc_o  out  64  round constant for the datapath rc input.
- rc2_o  out  64  round constant for the datapath rc2 input.

Behaviour:
- Reset: synchronous, active-high, highest priority. All outputs 0, state IDLE, counters 0. Asserting rst mid-operation aborts the run: no done_o, IDLE on the next cycle.
- FSM states: IDLE, LOAD, RUN, UPD, DONE.
- IDLE: busy_o=0. start_i=1 moves to LOAD.
- LOAD: one cycle; load_o=1, busy_o=1, round_o←1. Goes to RUN.
- RUN: en_o=rnd_valid_i. Latency counter cnt increments only when en_o=1. When cnt reaches SBOX_LAT-1 with en_o=1, go to UPD. If rnd_valid_i=0, hold: no en_o, no cnt change.
- UPD: one cycle; upd_o=1, en_o=0, cnt←0. If round_o=N_PASS go to DONE; otherwise round_o+1 and back to RUN.
- DONE: one cycle; done_o=1, busy_o=1. Goes to IDLE. start_i seen in DONE is ignored.
- busy_o=1 in LOAD, RUN, UPD and DONE. start_i is ignored whenever busy_o=1 (no queueing).
- Select schedule (valid in RUN and UPD):
  - rounds 1..5: inv_o=1, inv2_o=1.
  - round 6: inv_o=1, inv2_o=0.
  - rounds 7..11: inv_o=0, inv2_o=1.
  - All other states: inv_o=0, inv2_o=0.
- Constants: rc_o=RC[round_o], rc2_o=RC[round_o+1] (round 6 uses RC[7]); both 0 outside RUN/UPD.
- Outputs are registered or decoded from registered state only; no combinational path from start_i.
- Exception: en_o and rnd_ack_o follow rnd_valid_i combinationally in RUN.
- Latency with rnd_valid_i held at 1: start seen at edge 0, LOAD in cycle 1, passes in cycles 2..34, done_o in cycle 35. General total is 2 + N_PASS*(SBOX_LAT+1) cycles.
- Boundary: with SBOX_LAT=1, each pass is RUN (1 cycle) then UPD. round_o never exceeds 11 and never wraps.

Decomposition:
- Shared package prince_pkg holds:
  - RC[0..11] 64-bit round-constant table (standard PRINCE values, RC0=0, RC11=c0ac29b7c97c50dd);
  - state enum typedef;
  - N_PASS and MID_ROUND=6 constants.
- One sub-module, prince_rc_rom: combinational lookup from a 4-bit index to RC[index], instantiated twice (rc_o and rc2_o).

Test Plan:
- Reset then start_i=1 pulse, rnd_valid_i=1 → load_o at cycle 1. upd_o at cycles 4,7,…,34 (11 pulses). done_o only at cycle 35. busy_o high cycles 1..35.
- Same run, check per-pass selects → inv_o=1 for rounds 1..6, 0 for rounds 7..11. inv2_o=0 only in round 6. rc_o in round 1 = 13198a2e03707344; rc2_o in round 6 = RC[7].
- Toggle rnd_valid_i low for 3 cycles inside round 4 RUN → en_o and rnd_ack_o low for exactly those cycles. done_o delayed to cycle 38. No extra upd_o.
- Assert rst in round 8 → every output 0 next cycle. No done_o. A new start then gives done_o 35 cycles after it.
- start_i held high continuously → exactly one run per 36 cycles. Second run's load_o falls in the cycle after its IDLE start sample.
- Integration with the round datapath, plaintext=0, k0=k1=0, random masks → unmasked result 818665aa0d02dfda when done_o is high.
